// File: rtl/simprisc_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : simprisc_lsu_if
// Description : Execute-request, memory-port and writeback bundle of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface simprisc_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_base;
    logic [15:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_misaligned;
    logic        err_timeout;

    // LSU side
    modport slave (
        input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
        output req_ready,
        output mem_req, mem_addr, mem_wdata, mem_rw,
        input  mem_ack, mem_rdata,
        output wb_valid, wb_rd, wb_data, err_misaligned, err_timeout
    );

    // Execute / memory / writeback side
    modport master (
        output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
        input  req_ready,
        input  mem_req, mem_addr, mem_wdata, mem_rw,
        output mem_ack, mem_rdata,
        input  wb_valid, wb_rd, wb_data, err_misaligned, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/simprisc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : simprisc_lsu
// Description : SimpRisc load/store unit: EA calc, req/ack memory port,
//               load writeback, misalignment and timeout flags.
// Revision    : 1.0 - initial release
// ============================================================================
module simprisc_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  wire logic      clk,
    input  wire logic      nreset,
    simprisc_lsu_if.slave  bus
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_REQ      = 1'b1;
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [7:0]  r_cnt,        w_cnt;
    logic        r_req_ready,  w_req_ready;
    logic        r_mem_req,    w_mem_req;
    logic [31:0] r_mem_addr,   w_mem_addr;
    logic [31:0] r_mem_wdata,  w_mem_wdata;
    logic        r_mem_rw,     w_mem_rw;
    logic [4:0]  r_rd,         w_rd;
    logic        r_wb_valid,   w_wb_valid;
    logic [4:0]  r_wb_rd,      w_wb_rd;
    logic [31:0] r_wb_data,    w_wb_data;
    logic        r_err_mis,    w_err_mis;
    logic        r_err_to,     w_err_to;

    logic [31:0] w_ea;
    logic        w_accept;
    logic        w_aligned;
    logic        w_expired;

    assign w_ea      = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
    assign w_aligned = (w_ea[1:0] == 2'b00);
    assign w_accept  = bus.req_valid && r_req_ready;
    // r_cnt counts completed REQ cycles, so this is the TIMEOUT-th cycle
    assign w_expired = (r_cnt == c_CNT_LAST);

    // State register together with every registered output
    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 8'd0;
            r_req_ready <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_rw    <= 1'b0;
            r_rd        <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_err_mis   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_mem_req   <= w_mem_req;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_rw    <= w_mem_rw;
            r_rd        <= w_rd;
            r_wb_valid  <= w_wb_valid;
            r_wb_rd     <= w_wb_rd;
            r_wb_data   <= w_wb_data;
            r_err_mis   <= w_err_mis;
            r_err_to    <= w_err_to;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && w_aligned) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                if (bus.mem_ack || w_expired) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_cnt       = r_cnt;
        w_mem_req   = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_rw    = r_mem_rw;
        w_rd        = r_rd;
        w_wb_valid  = 1'b0;
        w_wb_rd     = r_wb_rd;
        w_wb_data   = r_wb_data;
        w_err_mis   = 1'b0;
        w_err_to    = 1'b0;
        w_req_ready = (w_state_nxt == c_IDLE);

        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (!w_aligned) begin
                        w_err_mis = 1'b1;
                    end else begin
                        w_cnt       = 8'd0;
                        w_mem_req   = 1'b1;
                        w_mem_addr  = w_ea;
                        w_mem_wdata = bus.req_wdata;
                        w_mem_rw    = bus.req_is_store;
                        w_rd        = bus.req_rd;
                    end
                end
            end
            c_REQ: begin
                w_cnt     = r_cnt + 8'd1;
                w_mem_req = 1'b1;
                // Ack on the expiring cycle still completes normally
                if (bus.mem_ack) begin
                    w_mem_req = 1'b0;
                    if (!r_mem_rw) begin
                        w_wb_valid = (r_rd != 5'd0);
                        w_wb_rd    = r_rd;
                        w_wb_data  = bus.mem_rdata;
                    end
                end else if (w_expired) begin
                    w_mem_req = 1'b0;
                    w_err_to  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.mem_rw         = r_mem_rw;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.wb_rd          = r_wb_rd;
    assign bus.wb_data        = r_wb_data;
    assign bus.err_misaligned = r_err_mis;
    assign bus.err_timeout    = r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_simprisc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_simprisc_lsu
// Description : Directed self-checking bench for simprisc_lsu (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simprisc_lsu;

    logic clk;
    logic nreset;
    int   n_pass;
    int   n_total;

    simprisc_lsu_if bus ();

    simprisc_lsu #(.TIMEOUT(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [31:0] base,
                         input logic [15:0] off, input logic [31:0] wd,
                         input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        step(); step();
        n_total++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready act=%b exp=0", bus.req_ready); else n_pass++;
        n_total++; if ({bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== 66'd0)
            $display("FAIL rst_mem act=%b/%b/%h/%h exp=0", bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_wdata); else n_pass++;
        n_total++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err_misaligned, bus.err_timeout} !== 40'd0)
            $display("FAIL rst_wb act=%b/%h/%h/%b/%b exp=0", bus.wb_valid, bus.wb_rd, bus.wb_data,
                     bus.err_misaligned, bus.err_timeout); else n_pass++;
        nreset = 1'b0;
        step();
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready act=%b exp=1", bus.req_ready); else n_pass++;
    endtask

    task automatic test_aligned_load();
        issue(1'b0, 32'h0000_0100, 16'h0004, 32'h0, 5'd3);
        step();
        bus.req_valid = 1'b0;
        n_total++; if ({bus.mem_req, bus.mem_rw, bus.req_ready} !== 3'b100)
            $display("FAIL ld_req1 act=%b%b%b exp=100", bus.mem_req, bus.mem_rw, bus.req_ready); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'h0000_0104) $display("FAIL ld_addr act=%h exp=00000104", bus.mem_addr); else n_pass++;
        step();
        n_total++; if ({bus.mem_req, bus.req_ready, bus.wb_valid} !== 3'b100)
            $display("FAIL ld_req2 act=%b%b%b exp=100", bus.mem_req, bus.req_ready, bus.wb_valid); else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.mem_req, bus.req_ready, bus.wb_valid} !== 3'b011)
            $display("FAIL ld_done act=%b%b%b exp=011", bus.mem_req, bus.req_ready, bus.wb_valid); else n_pass++;
        n_total++; if ({bus.wb_rd, bus.wb_data} !== {5'd3, 32'hDEAD_BEEF})
            $display("FAIL ld_wb act=%0d/%h exp=3/deadbeef", bus.wb_rd, bus.wb_data); else n_pass++;
        step();
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL ld_wb_pulse act=%b exp=0", bus.wb_valid); else n_pass++;
    endtask

    task automatic test_store_neg_offset();
        issue(1'b1, 32'h0000_0200, 16'hFFF8, 32'h1234_5678, 5'd9);
        step();
        bus.req_valid = 1'b0;
        n_total++; if ({bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h0000_01F8, 32'h1234_5678})
            $display("FAIL st_req act=%b/%b/%h/%h exp=1/1/000001f8/12345678",
                     bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_wdata); else n_pass++;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.mem_req, bus.wb_valid, bus.req_ready} !== 3'b001)
            $display("FAIL st_done act=%b%b%b exp=001", bus.mem_req, bus.wb_valid, bus.req_ready); else n_pass++;
    endtask

    task automatic test_misaligned_back_to_back();
        issue(1'b0, 32'h0000_0100, 16'h0002, 32'h0, 5'd4);
        step();
        n_total++; if ({bus.err_misaligned, bus.mem_req, bus.req_ready, bus.wb_valid} !== 4'b1010)
            $display("FAIL mis_pulse act=%b%b%b%b exp=1010", bus.err_misaligned, bus.mem_req,
                     bus.req_ready, bus.wb_valid); else n_pass++;
        issue(1'b0, 32'h0000_0100, 16'h0000, 32'h0, 5'd5);
        step();
        bus.req_valid = 1'b0;
        n_total++; if ({bus.err_misaligned, bus.mem_req, bus.mem_addr} !== {2'b01, 32'h0000_0100})
            $display("FAIL b2b_req act=%b/%b/%h exp=0/1/00000100", bus.err_misaligned, bus.mem_req,
                     bus.mem_addr); else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'hCAFE_F00D})
            $display("FAIL b2b_wb act=%b/%0d/%h exp=1/5/cafef00d", bus.wb_valid, bus.wb_rd, bus.wb_data); else n_pass++;
    endtask

    task automatic test_timeout();
        int hi;
        issue(1'b0, 32'h0000_0300, 16'h0000, 32'h0, 5'd7);
        step();
        bus.req_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req === 1'b1 && bus.err_timeout === 1'b0) hi++;
            step();
        end
        n_total++; if (hi != 4) $display("FAIL to_req_cycles act=%0d exp=4", hi); else n_pass++;
        n_total++; if ({bus.mem_req, bus.err_timeout, bus.wb_valid, bus.req_ready} !== 4'b0101)
            $display("FAIL to_abort act=%b%b%b%b exp=0101", bus.mem_req, bus.err_timeout,
                     bus.wb_valid, bus.req_ready); else n_pass++;
        step();
        n_total++; if ({bus.err_timeout, bus.wb_valid} !== 2'b00)
            $display("FAIL to_pulse act=%b%b exp=00", bus.err_timeout, bus.wb_valid); else n_pass++;

        issue(1'b0, 32'h0000_0300, 16'h0000, 32'h0, 5'd7);
        step();
        bus.req_valid = 1'b0;
        step(); step(); step();
        n_total++; if ({bus.mem_req, bus.err_timeout} !== 2'b10)
            $display("FAIL to_4th_cycle act=%b%b exp=10", bus.mem_req, bus.err_timeout); else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55AA_00FF;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.mem_req, bus.err_timeout, bus.wb_valid, bus.wb_rd, bus.wb_data} !== {3'b001, 5'd7, 32'h55AA_00FF})
            $display("FAIL to_ack_wins act=%b%b%b/%0d/%h exp=001/7/55aa00ff", bus.mem_req, bus.err_timeout,
                     bus.wb_valid, bus.wb_rd, bus.wb_data); else n_pass++;
        step();
    endtask

    task automatic test_r0_wrap();
        issue(1'b0, 32'hFFFF_FFFC, 16'h0008, 32'h0, 5'd0);
        step();
        bus.req_valid = 1'b0;
        n_total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_0004})
            $display("FAIL wrap_addr act=%b/%h exp=1/00000004", bus.mem_req, bus.mem_addr); else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.mem_req, bus.wb_valid, bus.err_misaligned, bus.err_timeout, bus.req_ready} !== 5'b00001)
            $display("FAIL r0_no_wb act=%b%b%b%b%b exp=00001", bus.mem_req, bus.wb_valid,
                     bus.err_misaligned, bus.err_timeout, bus.req_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        issue(1'b0, 32'h0000_0400, 16'h0000, 32'h0, 5'd9);
        step();
        bus.req_valid = 1'b0;
        n_total++; if (bus.mem_req !== 1'b1) $display("FAIL mid_pre act=%b exp=1", bus.mem_req); else n_pass++;
        nreset = 1'b1;
        step();
        nreset = 1'b0;
        n_total++; if ({bus.mem_req, bus.req_ready} !== 2'b00)
            $display("FAIL mid_rst act=%b%b exp=00", bus.mem_req, bus.req_ready); else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h9999_9999;
        step();
        bus.mem_ack = 1'b0;
        n_total++; if ({bus.req_ready, bus.mem_req, bus.wb_valid} !== 3'b100)
            $display("FAIL mid_release act=%b%b%b exp=100", bus.req_ready, bus.mem_req, bus.wb_valid); else n_pass++;
        step();
        n_total++; if ({bus.mem_req, bus.wb_valid, bus.err_timeout} !== 3'b000)
            $display("FAIL mid_late_ack act=%b%b%b exp=000", bus.mem_req, bus.wb_valid, bus.err_timeout); else n_pass++;
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        nreset           = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_base     = 32'd0;
        bus.req_offset   = 16'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rd       = 5'd0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'd0;

        test_reset();
        test_aligned_load();
        test_store_neg_offset();
        test_misaligned_back_to_back();
        test_timeout();
        test_r0_wrap();
        test_reset_mid_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
